// File: rtl/draw_engine_arbiter.sv
// draw_engine_arbiter: round-robin share of one pixel plotter between NREQ sprite requesters.
// Flow: IDLE -> LAUNCH (1 cycle, drw_start) -> WAIT (until drw_done) -> RELEASE (1 cycle, done).
// Ports: req/req_x/req_y/req_colour in (packed per requester), grant/done out (one-hot),
//   drw_start/drw_x/drw_y/drw_colour to plotter, drw_done from plotter, busy, timeout_err.
// Optional macro DRAW_ARB_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT cycles; without it
//   WAIT holds indefinitely and timeout_err is tied low.
module draw_engine_arbiter #(
  parameter int NREQ    = 3,
  parameter int XW      = 8,
  parameter int YW      = 7,
  parameter int CW      = 3,
  parameter int TIMEOUT = 20000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*XW-1:0] req_x,
  input  logic [NREQ*YW-1:0] req_y,
  input  logic [NREQ*CW-1:0] req_colour,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic               drw_start,
  output logic [XW-1:0]      drw_x,
  output logic [YW-1:0]      drw_y,
  output logic [CW-1:0]      drw_colour,
  input  logic               drw_done,
  output logic               busy,
  output logic               timeout_err
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("draw_engine_arbiter: NREQ must be in 2..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 32767) begin : g_bad_timeout
    $error("draw_engine_arbiter: TIMEOUT must fit the 15-bit watchdog");
  end

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RELEASE} state_t;

  state_t          state, state_nxt;
  logic [LW-1:0]   last;      // most recently serviced requester
  logic [LW-1:0]   win;       // requester currently being drawn
  logic [LW-1:0]   pick;
  logic [NREQ-1:0] mask;      // blocks the just-serviced requester for one IDLE cycle
  logic [NREQ-1:0] eligible;
  logic [LW:0]     cand;
  logic            found;
  logic            wd_fire;
  logic            release_now;

  // Search last+1, last+2, ... wrapping once; cand never exceeds 2*NREQ-1 so a single
  // conditional subtract is enough for the modulo.
  always_comb begin
    eligible = req & ~mask;
    found    = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = {1'b0, last} + (LW+1)'(i);
      if (cand >= (LW+1)'(NREQ)) cand = cand - (LW+1)'(NREQ);
      if (!found && eligible[cand[LW-1:0]]) begin
        found = 1'b1;
        pick  = cand[LW-1:0];
      end
    end
  end

`ifdef DRAW_ARB_TIMEOUT_EN
  localparam logic [14:0] WD_LAST = 15'(TIMEOUT - 1);
  logic [14:0] wd_cnt;

  // Counter is zeroed in LAUNCH so it starts at 0 on the first WAIT cycle; it fires on
  // the edge that ends the TIMEOUT-th WAIT cycle.
  assign wd_fire = (state == WAIT) && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == LAUNCH)    wd_cnt <= '0;
      else if (state == WAIT) wd_cnt <= wd_cnt + 15'd1;
      if (wd_fire && !drw_done) timeout_err <= 1'b1;
    end
  end
`else
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign release_now = drw_done || wd_fire;
  assign busy        = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      WAIT:    if (release_now) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last       <= LW'(NREQ - 1);
      win        <= '0;
      mask       <= '0;
      grant      <= '0;
      done       <= '0;
      drw_start  <= 1'b0;
      drw_x      <= '0;
      drw_y      <= '0;
      drw_colour <= '0;
    end else begin
      state     <= state_nxt;
      drw_start <= 1'b0;
      done      <= '0;
      case (state)
        IDLE: begin
          mask <= '0;
          if (found) begin
            win        <= pick;
            grant      <= NREQ'(1) << pick;
            drw_start  <= 1'b1;
            drw_x      <= req_x[int'(pick)*XW +: XW];
            drw_y      <= req_y[int'(pick)*YW +: YW];
            drw_colour <= req_colour[int'(pick)*CW +: CW];
          end
        end
        WAIT: begin
          if (release_now) begin
            done  <= NREQ'(1) << win;
            grant <= '0;
            last  <= win;
            mask  <= NREQ'(1) << win;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_engine_arbiter.sv
module tb_draw_engine_arbiter;
  localparam int NREQ = 3, XW = 8, YW = 7, CW = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*XW-1:0] req_x = '0;
  logic [NREQ*YW-1:0] req_y = '0;
  logic [NREQ*CW-1:0] req_colour = '0;
  logic               drw_done = 1'b0;
  logic [NREQ-1:0]    grant, done;
  logic               drw_start, busy, timeout_err;
  logic [XW-1:0]      drw_x;
  logic [YW-1:0]      drw_y;
  logic [CW-1:0]      drw_colour;

  typedef struct packed {
    logic [NREQ-1:0] g;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [CW-1:0]   c;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int n_checks = 0;
  int n_fail = 0;

  draw_engine_arbiter #(.NREQ(NREQ), .XW(XW), .YW(YW), .CW(CW), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_x(req_x), .req_y(req_y),
    .req_colour(req_colour), .grant(grant), .done(done), .drw_start(drw_start),
    .drw_x(drw_x), .drw_y(drw_y), .drw_colour(drw_colour), .drw_done(drw_done),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [XW-1:0] x, input logic [YW-1:0] y,
                         input logic [CW-1:0] c);
    req_x[i*XW +: XW]      = x;
    req_y[i*YW +: YW]      = y;
    req_colour[i*CW +: CW] = c;
  endtask

  task automatic push(input logic [NREQ-1:0] g, input logic [XW-1:0] x,
                      input logic [YW-1:0] y, input logic [CW-1:0] c);
    exp_t t;
    t.g = g; t.x = x; t.y = y; t.c = c;
    exp_q.push_back(t);
  endtask

  // Cycles until drw_start is seen, or -1 if it never comes within the budget.
  task automatic wait_start(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (drw_start === 1'b1) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({grant, done, drw_start, drw_x, drw_y, drw_colour, busy, timeout_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: grant=%b done=%b start=%b x=%0d y=%0d c=%0d busy=%b terr=%b, want all 0",
               grant, done, drw_start, drw_x, drw_y, drw_colour, busy, timeout_err);
    end
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || grant !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b grant=%b, want 0/000", busy, grant);
    end
  endtask

  task automatic test_round_robin();
    int cyc;
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(10 + i), 7'(20 + i), 3'(i + 1));
    push(3'b001, 8'd10, 7'd20, 3'd1);
    push(3'b010, 8'd11, 7'd21, 3'd2);
    push(3'b100, 8'd12, 7'd22, 3'd3);
    push(3'b001, 8'd10, 7'd20, 3'd1);
    req = 3'b111;
    for (int d = 0; d < 4; d++) begin
      wait_start(cyc);
      e = exp_q.pop_front();
      n_checks++;
      if (cyc < 0 || {grant, drw_x, drw_y, drw_colour} !== e) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: cyc=%0d grant=%b x=%0d y=%0d c=%0d, want grant=%b x=%0d y=%0d c=%0d",
                 d, cyc, grant, drw_x, drw_y, drw_colour, e.g, e.x, e.y, e.c);
      end
      if (d == 0) begin
        n_checks++;
        if (cyc !== 1) begin
          n_fail++;
          $display("FAIL rr_latency: start after %0d cycles, want 1", cyc);
        end
      end
      repeat (4) tick();
      drw_done = 1'b1;
      tick();
      drw_done = 1'b0;
      if (d == 3) req = '0;
      n_checks++;
      if (done !== e.g || grant !== '0) begin
        n_fail++;
        $display("FAIL rr_done[%0d]: done=%b grant=%b, want done=%b grant=000", d, done, grant, e.g);
      end
      tick();
      n_checks++;
      if (done !== '0) begin
        n_fail++;
        $display("FAIL rr_done_pulse[%0d]: done=%b, want 000", d, done);
      end
    end
  endtask

  task automatic test_latch();
    int cyc;
    set_req(0, 8'd1, 7'd1, 3'd1);
    set_req(1, 8'd40, 7'd60, 3'd5);
    set_req(2, 8'd2, 7'd2, 3'd2);
    push(3'b010, 8'd40, 7'd60, 3'd5);
    req = 3'b010;
    wait_start(cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (cyc !== 1 || {grant, drw_x, drw_y, drw_colour} !== e) begin
      n_fail++;
      $display("FAIL latch: cyc=%0d grant=%b x=%0d y=%0d c=%0d, want cyc=1 grant=%b x=%0d y=%0d c=%0d",
               cyc, grant, drw_x, drw_y, drw_colour, e.g, e.x, e.y, e.c);
    end
    // drw_done during LAUNCH must not end the draw
    drw_done = 1'b1;
    tick();
    drw_done = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== '0 || grant !== 3'b010 || drw_start !== 1'b0) begin
      n_fail++;
      $display("FAIL launch_done_ignored: busy=%b done=%b grant=%b start=%b, want 1/000/010/0",
               busy, done, grant, drw_start);
    end
  endtask

  task automatic test_change_while_granted();
    set_req(1, 8'd99, 7'd10, 3'd2);
    tick();
    n_checks++;
    if (drw_x !== 8'd40 || drw_y !== 7'd60 || drw_colour !== 3'd5) begin
      n_fail++;
      $display("FAIL hold_origin: x=%0d y=%0d c=%0d, want 40/60/5", drw_x, drw_y, drw_colour);
    end
    req = '0;
    repeat (2) tick();
    n_checks++;
    if (grant !== 3'b010 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_req_grant: grant=%b busy=%b, want 010/1", grant, busy);
    end
    drw_done = 1'b1;
    tick();
    n_checks++;
    if (done !== 3'b010) begin
      n_fail++;
      $display("FAIL drop_req_done: done=%b, want 010", done);
    end
    // drw_done held through RELEASE and IDLE: no effect
    repeat (2) tick();
    drw_done = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== '0 || grant !== '0) begin
      n_fail++;
      $display("FAIL stray_done: busy=%b done=%b grant=%b, want 0/000/000", busy, done, grant);
    end
  endtask

  task automatic test_sole_requester();
    int cyc;
    set_req(0, 8'd5, 7'd6, 3'd7);
    push(3'b001, 8'd5, 7'd6, 3'd7);
    push(3'b001, 8'd5, 7'd6, 3'd7);
    req = 3'b001;
    for (int d = 0; d < 2; d++) begin
      wait_start(cyc);
      e = exp_q.pop_front();
      n_checks++;
      // second start: RELEASE, masked IDLE, unmasked IDLE -> 3 cycles after done
      if (cyc !== ((d == 0) ? 1 : 3) || {grant, drw_x, drw_y, drw_colour} !== e) begin
        n_fail++;
        $display("FAIL sole[%0d]: cyc=%0d grant=%b x=%0d, want cyc=%0d grant=%b x=%0d",
                 d, cyc, grant, drw_x, (d == 0) ? 1 : 3, e.g, e.x);
      end
      repeat (2) tick();
      drw_done = 1'b1;
      tick();
      drw_done = 1'b0;
      if (d == 1) req = '0;
      n_checks++;
      if (done !== 3'b001) begin
        n_fail++;
        $display("FAIL sole_done[%0d]: done=%b, want 001", d, done);
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    int cyc;
    set_req(0, 8'd70, 7'd71, 3'd3);
    set_req(1, 8'd80, 7'd81, 3'd4);
    push(3'b010, 8'd80, 7'd81, 3'd4);
    push(3'b001, 8'd70, 7'd71, 3'd3);
    req = 3'b011;
    for (int d = 0; d < 2; d++) begin
      wait_start(cyc);
      e = exp_q.pop_front();
      n_checks++;
      if (cyc !== ((d == 0) ? 1 : 2) || {grant, drw_x, drw_y, drw_colour} !== e) begin
        n_fail++;
        $display("FAIL b2b[%0d]: cyc=%0d grant=%b x=%0d, want cyc=%0d grant=%b x=%0d",
                 d, cyc, grant, drw_x, (d == 0) ? 1 : 2, e.g, e.x);
      end
      tick();
      drw_done = 1'b1;
      tick();
      drw_done = 1'b0;
      req = (d == 0) ? 3'b001 : 3'b000;
      n_checks++;
      if (done !== e.g) begin
        n_fail++;
        $display("FAIL b2b_done[%0d]: done=%b, want %b", d, done, e.g);
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_draw();
    int cyc;
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(30 + i), 7'(40 + i), 3'(i + 2));
    push(3'b010, 8'd31, 7'd41, 3'd3);
    req = 3'b111;
    wait_start(cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (cyc < 0 || {grant, drw_x, drw_y, drw_colour} !== e) begin
      n_fail++;
      $display("FAIL pre_reset_grant: grant=%b x=%0d, want %b x=%0d", grant, drw_x, e.g, e.x);
    end
    repeat (2) tick();
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (grant !== '0 || busy !== 1'b0 || drw_start !== 1'b0 || drw_x !== '0 || done !== '0) begin
      n_fail++;
      $display("FAIL async_reset: grant=%b busy=%b start=%b x=%0d done=%b, want all 0",
               grant, busy, drw_start, drw_x, done);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    push(3'b001, 8'd30, 7'd40, 3'd2);
    wait_start(cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (cyc !== 1 || {grant, drw_x, drw_y, drw_colour} !== e) begin
      n_fail++;
      $display("FAIL post_reset_grant: cyc=%0d grant=%b x=%0d, want cyc=1 grant=%b x=%0d",
               cyc, grant, drw_x, e.g, e.x);
    end
    tick();
    drw_done = 1'b1;
    tick();
    drw_done = 1'b0;
    req = '0;
    n_checks++;
    if (done !== 3'b001) begin
      n_fail++;
      $display("FAIL post_reset_done: done=%b, want 001", done);
    end
    repeat (2) tick();
  endtask

  task automatic test_timeout();
    int cyc;
    set_req(2, 8'd120, 7'd100, 3'd6);
    push(3'b100, 8'd120, 7'd100, 3'd6);
    req = 3'b100;
    wait_start(cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (cyc !== 1 || {grant, drw_x, drw_y, drw_colour} !== e) begin
      n_fail++;
      $display("FAIL wd_grant: cyc=%0d grant=%b x=%0d, want cyc=1 grant=%b x=%0d",
               cyc, grant, drw_x, e.g, e.x);
    end
`ifdef DRAW_ARB_TIMEOUT_EN
    cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done !== '0) begin
        cyc = k;
        break;
      end
    end
    req = '0;
    // one LAUNCH cycle plus 16 WAIT cycles before done shows
    n_checks++;
    if (cyc !== 17 || done !== 3'b100 || timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_fire: cyc=%0d done=%b terr=%b, want 17/100/1", cyc, done, timeout_err);
    end
    repeat (3) tick();
    n_checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_sticky: terr=%b busy=%b, want 1/0", timeout_err, busy);
    end
`else
    repeat (40) tick();
    n_checks++;
    if (busy !== 1'b1 || grant !== 3'b100 || done !== '0 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_hold: busy=%b grant=%b done=%b terr=%b, want 1/100/000/0",
               busy, grant, done, timeout_err);
    end
    drw_done = 1'b1;
    tick();
    drw_done = 1'b0;
    req = '0;
    n_checks++;
    if (done !== 3'b100) begin
      n_fail++;
      $display("FAIL wait_hold_done: done=%b, want 100", done);
    end
    repeat (2) tick();
`endif
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_latch();
    test_change_while_granted();
    test_sole_requester();
    test_back_to_back();
    test_reset_mid_draw();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
